// File: rtl/s6_icap_pkg.sv
// Shared constants, state encoding and helpers for the Spartan-6 ICAP IPROG reboot sequencer.
package s6_icap_pkg;

    localparam logic [15:0] ICAP_DUMMY     = 16'hFFFF;
    localparam logic [15:0] ICAP_SYNC0     = 16'hAA99;
    localparam logic [15:0] ICAP_SYNC1     = 16'h5566;
    localparam logic [15:0] ICAP_WR_GEN1   = 16'h3261;
    localparam logic [15:0] ICAP_WR_GEN2   = 16'h3281;
    localparam logic [15:0] ICAP_WR_GEN3   = 16'h32A1;
    localparam logic [15:0] ICAP_WR_GEN4   = 16'h32C1;
    localparam logic [15:0] ICAP_WR_CMD    = 16'h30A1;
    localparam logic [15:0] ICAP_CMD_IPROG = 16'h000E;
    localparam logic [15:0] ICAP_NOOP      = 16'h2000;

    localparam int IPROG_LEN = 14;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACKLOW,
        ST_ISSUE,
        ST_NEXT,
        ST_DONE,
        ST_ERR
    } icap_state_e;

    // ICAP_SPARTAN6 expects each byte presented MSB-first on the opposite pins.
    function automatic logic [15:0] bitswap_bytes(input logic [15:0] w);
        logic [15:0] r;
        for (int b = 0; b < 2; b++) begin
            for (int j = 0; j < 8; j++) begin
                r[b*8 + j] = w[b*8 + 7 - j];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/s6_icap_reboot_ctrl_if.sv
// Wishbone write port between the reboot sequencer (master) and the ICAP slave.
interface s6_icap_reboot_ctrl_if;

    logic        cyc_o;
    logic        stb_o;
    logic        we_o;
    logic [31:0] dat_o;
    logic        ack_i;

    modport master (
        output cyc_o,
        output stb_o,
        output we_o,
        output dat_o,
        input  ack_i
    );

    modport slave (
        input  cyc_o,
        input  stb_o,
        input  we_o,
        input  dat_o,
        output ack_i
    );

endinterface

// File: rtl/s6_iprog_rom.sv
// Combinational IPROG command word table: word index plus latched addresses give the 16-bit ICAP word.
module s6_iprog_rom
    import s6_icap_pkg::*;
#(
    parameter bit BITSWAP = 1'b1
) (
    input  logic [3:0]  index,
    input  logic [23:0] multi_addr,
    input  logic [23:0] golden_addr,
    input  logic [7:0]  opcode,
    output logic [15:0] word
);

    logic [15:0] raw;

    always_comb begin
        raw = ICAP_NOOP;
        case (index)
            4'd0:    raw = ICAP_DUMMY;
            4'd1:    raw = ICAP_SYNC0;
            4'd2:    raw = ICAP_SYNC1;
            4'd3:    raw = ICAP_WR_GEN1;
            4'd4:    raw = multi_addr[15:0];
            4'd5:    raw = ICAP_WR_GEN2;
            4'd6:    raw = {opcode, multi_addr[23:16]};
            4'd7:    raw = ICAP_WR_GEN3;
            4'd8:    raw = golden_addr[15:0];
            4'd9:    raw = ICAP_WR_GEN4;
            4'd10:   raw = {opcode, golden_addr[23:16]};
            4'd11:   raw = ICAP_WR_CMD;
            4'd12:   raw = ICAP_CMD_IPROG;
            4'd13:   raw = ICAP_NOOP;
            default: raw = ICAP_NOOP;
        endcase
    end

    assign word = BITSWAP ? bitswap_bytes(raw) : raw;

endmodule

// File: rtl/s6_icap_reboot_ctrl.sv
// Wishbone master that streams the IPROG command sequence into the Spartan-6 ICAP slave
// to trigger a multiboot reconfiguration with a golden fallback address.
module s6_icap_reboot_ctrl
    import s6_icap_pkg::*;
#(
    parameter logic [7:0] SPI_RD_OPCODE = 8'h0B,
    parameter bit         BITSWAP       = 1'b1,
    parameter int         TIMEOUT       = 1023
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [23:0]                  multi_addr,
    input  logic [23:0]                  golden_addr,
    output logic                         busy,
    output logic                         done,
    output logic                         error,
    s6_icap_reboot_ctrl_if.master        wb
);

    localparam logic [9:0] TIMEOUT_CNT = 10'(TIMEOUT);
    localparam logic [3:0] LAST_INDEX  = 4'(IPROG_LEN - 1);

    icap_state_e state_q, state_d;
    logic [3:0]  index_q, index_d;
    logic [9:0]  cnt_q, cnt_d;
    logic [23:0] multi_q, multi_d;
    logic [23:0] golden_q, golden_d;
    logic        done_q, done_d;
    logic        error_q, error_d;
    logic [15:0] rom_word;
    logic        issuing;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            index_q  <= '0;
            cnt_q    <= '0;
            multi_q  <= '0;
            golden_q <= '0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            index_q  <= index_d;
            cnt_q    <= cnt_d;
            multi_q  <= multi_d;
            golden_q <= golden_d;
            done_q   <= done_d;
            error_q  <= error_d;
        end
    end

    // ACKLOW guards against a slow ICAP still holding ack from the previous word.
    always_comb begin
        state_d  = state_q;
        index_d  = index_q;
        cnt_d    = cnt_q;
        multi_d  = multi_q;
        golden_d = golden_q;
        done_d   = done_q;
        error_d  = error_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    multi_d  = multi_addr;
                    golden_d = golden_addr;
                    done_d   = 1'b0;
                    error_d  = 1'b0;
                    index_d  = '0;
                    cnt_d    = '0;
                    state_d  = ST_ACKLOW;
                end
            end
            ST_ACKLOW: begin
                if (!wb.ack_i) begin
                    cnt_d   = '0;
                    state_d = ST_ISSUE;
                end else if (cnt_q == TIMEOUT_CNT) begin
                    state_d = ST_ERR;
                end else begin
                    cnt_d = cnt_q + 10'd1;
                end
            end
            ST_ISSUE: begin
                if (wb.ack_i) begin
                    cnt_d   = '0;
                    state_d = ST_NEXT;
                end else if (cnt_q == TIMEOUT_CNT) begin
                    state_d = ST_ERR;
                end else begin
                    cnt_d = cnt_q + 10'd1;
                end
            end
            ST_NEXT: begin
                if (index_q == LAST_INDEX) begin
                    state_d = ST_DONE;
                end else begin
                    index_d = index_q + 4'd1;
                    state_d = ST_ACKLOW;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            ST_ERR: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Status flags rise together with busy falling.
        if (state_d == ST_DONE) begin
            done_d = 1'b1;
        end
        if (state_d == ST_ERR) begin
            error_d = 1'b1;
        end
    end

    s6_iprog_rom #(
        .BITSWAP (BITSWAP)
    ) u_rom (
        .index       (index_q),
        .multi_addr  (multi_q),
        .golden_addr (golden_q),
        .opcode      (SPI_RD_OPCODE),
        .word        (rom_word)
    );

    assign issuing  = (state_q == ST_ISSUE);
    assign wb.cyc_o = issuing;
    assign wb.stb_o = issuing;
    assign wb.we_o  = issuing;
    assign wb.dat_o = issuing ? {16'h0000, rom_word} : 32'h0;

    assign busy  = (state_q == ST_ACKLOW) || (state_q == ST_ISSUE) || (state_q == ST_NEXT);
    assign done  = done_q;
    assign error = error_q;

endmodule

// File: tb/tb_s6_icap_reboot_ctrl.sv
// Self-checking bench: two sequencers (BITSWAP 0 and 1) share one ICAP slave model and are
// compared word-by-word against a reference list of the IPROG stream.
module tb_s6_icap_reboot_ctrl;

    localparam int TIMEOUT = 1023;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [23:0] multi_addr;
    logic [23:0] golden_addr;
    logic        busy0, done0, error0;
    logic        busy1, done1, error1;
    logic        ack;

    s6_icap_reboot_ctrl_if wb0 ();
    s6_icap_reboot_ctrl_if wb1 ();

    assign wb0.ack_i = ack;
    assign wb1.ack_i = ack;

    always #5 clk = ~clk;

    s6_icap_reboot_ctrl #(
        .SPI_RD_OPCODE (8'h0B),
        .BITSWAP       (1'b0),
        .TIMEOUT       (TIMEOUT)
    ) dut0 (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .multi_addr  (multi_addr),
        .golden_addr (golden_addr),
        .busy        (busy0),
        .done        (done0),
        .error       (error0),
        .wb          (wb0)
    );

    s6_icap_reboot_ctrl #(
        .SPI_RD_OPCODE (8'h0B),
        .BITSWAP       (1'b1),
        .TIMEOUT       (TIMEOUT)
    ) dut1 (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .multi_addr  (multi_addr),
        .golden_addr (golden_addr),
        .busy        (busy1),
        .done        (done1),
        .error       (error1),
        .wb          (wb1)
    );

    int          nassert = 0;
    int          nfail   = 0;
    int          ack_delay = 4;
    int          ack_hold  = 3;
    int          nack_abs  = -100;
    int          base      = 0;
    logic [31:0] log_w0 [$];
    logic [31:0] log_w1 [$];
    logic        stb_seen = 1'b0;
    int          cyc_run  = 0;
    int          last_run = 0;
    int          dly = 0;
    int          hld = 0;

    // Slave model: ack after ack_delay clocks of strobe, hold it for ack_hold clocks,
    // and never ack the word whose absolute log position equals nack_abs.
    always @(posedge clk) begin
        if (reset) begin
            ack <= 1'b0;
            dly <= 0;
            hld <= 0;
        end else if (hld != 0) begin
            hld <= hld - 1;
            if (hld == 1) ack <= 1'b0;
        end else if (wb0.stb_o && !ack && (log_w0.size() - 1 != nack_abs)) begin
            if (dly + 1 >= ack_delay) begin
                ack <= 1'b1;
                hld <= ack_hold;
                dly <= 0;
            end else begin
                dly <= dly + 1;
            end
        end else begin
            dly <= 0;
        end
    end

    // Record each new strobe's data and measure how long each cycle stays open.
    always @(negedge clk) begin
        if (wb0.stb_o && !stb_seen) begin
            log_w0.push_back(wb0.dat_o);
            log_w1.push_back(wb1.dat_o);
        end
        stb_seen <= wb0.stb_o;
        if (wb0.cyc_o) begin
            cyc_run <= cyc_run + 1;
        end else begin
            if (cyc_run != 0) last_run <= cyc_run;
            cyc_run <= 0;
        end
    end

    function automatic logic [15:0] bit_rev_bytes(input logic [15:0] w);
        logic [15:0] t;
        t = {<<{w}};
        return {t[7:0], t[15:8]};
    endfunction

    function automatic logic [31:0] ref_word(input int k, input logic [23:0] m,
                                             input logic [23:0] g, input bit swap);
        logic [15:0] seq [14];
        seq = '{16'hFFFF, 16'hAA99, 16'h5566, 16'h3261, m[15:0], 16'h3281,
                {8'h0B, m[23:16]}, 16'h32A1, g[15:0], 16'h32C1, {8'h0B, g[23:16]},
                16'h30A1, 16'h000E, 16'h2000};
        return {16'h0000, swap ? bit_rev_bytes(seq[k]) : seq[k]};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nassert++;
        if (act !== exp) begin
            nfail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [23:0] m, input logic [23:0] g,
                                 input int d, input int h, input int nack);
        @(negedge clk);
        ack_delay   = d;
        ack_hold    = h;
        base        = log_w0.size();
        nack_abs    = (nack < 0) ? -100 : base + nack;
        multi_addr  = m;
        golden_addr = g;
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("busy_after_start", {31'h0, busy0}, 32'h1);
        checkOutput("done_cleared", {31'h0, done0}, 32'h0);
        checkOutput("error_cleared", {31'h0, error0}, 32'h0);
    endtask

    task automatic waitEnd(input int budget);
        int n = 0;
        while (!(done0 || error0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!(done0 || error0)) begin
            nassert++;
            nfail++;
            $display("[TB] FAIL wait_end: no done/error within %0d cycles", budget);
        end
    endtask

    task automatic waitWords(input int words, input int budget);
        int n = 0;
        while ((log_w0.size() - base) < words && n < budget) begin
            @(negedge clk);
            n++;
        end
        if ((log_w0.size() - base) < words) begin
            nassert++;
            nfail++;
            $display("[TB] FAIL wait_words: got %0d words, needed %0d", log_w0.size() - base, words);
        end
    endtask

    task automatic checkRun(input logic [23:0] m, input logic [23:0] g,
                            input bit exp_done, input bit exp_error, input int exp_count);
        int cnt;
        cnt = log_w0.size() - base;
        checkOutput("done", {31'h0, done0}, {31'h0, exp_done});
        checkOutput("error", {31'h0, error0}, {31'h0, exp_error});
        checkOutput("busy_end", {31'h0, busy0}, 32'h0);
        checkOutput("done_swap", {31'h0, done1}, {31'h0, exp_done});
        checkOutput("error_swap", {31'h0, error1}, {31'h0, exp_error});
        checkOutput("strobe_count", cnt, exp_count);
        for (int k = 0; k < exp_count && k < cnt; k++) begin
            checkOutput($sformatf("word%0d_noswap", k), log_w0[base + k], ref_word(k, m, g, 1'b0));
            checkOutput($sformatf("word%0d_swap", k), log_w1[base + k], ref_word(k, m, g, 1'b1));
        end
    endtask

    typedef struct {
        logic [23:0] multi;
        logic [23:0] golden;
        int          delay;
        int          hold;
        int          nack;
        bit          exp_done;
        bit          exp_error;
        int          exp_count;
    } vec_t;

    vec_t vecs [4];

    initial begin
        vecs[0] = '{24'h040000, 24'h000000, 4, 3,  -1, 1'b1, 1'b0, 14};
        vecs[1] = '{24'h040000, 24'h000000, 4, 10, -1, 1'b1, 1'b0, 14};
        vecs[2] = '{24'h123456, 24'hABCDEF, 1, 1,  -1, 1'b1, 1'b0, 14};
        vecs[3] = '{24'h040000, 24'h000000, 4, 3,   3, 1'b0, 1'b1, 4};

        reset       = 1'b1;
        start       = 1'b0;
        multi_addr  = '0;
        golden_addr = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset_busy", {31'h0, busy0}, 32'h0);
        checkOutput("reset_done", {31'h0, done0}, 32'h0);
        checkOutput("reset_error", {31'h0, error0}, 32'h0);
        checkOutput("reset_cyc", {31'h0, wb0.cyc_o}, 32'h0);
        checkOutput("reset_stb", {31'h0, wb0.stb_o}, 32'h0);
        checkOutput("reset_we", {31'h0, wb0.we_o}, 32'h0);
        checkOutput("reset_dat", wb0.dat_o, 32'h0);
        reset = 1'b0;

        for (int i = 0; i < 4; i++) begin
            applyStimulus(vecs[i].multi, vecs[i].golden, vecs[i].delay, vecs[i].hold, vecs[i].nack);
            waitEnd(20000);
            checkRun(vecs[i].multi, vecs[i].golden, vecs[i].exp_done, vecs[i].exp_error,
                     vecs[i].exp_count);
            if (i == 0) begin
                checkOutput("t1_word4", log_w0[base + 4], 32'h0000_0000);
                checkOutput("t1_word6", log_w0[base + 6], 32'h0000_0B04);
                checkOutput("t1_word12", log_w0[base + 12], 32'h0000_000E);
                checkOutput("t1_word13", log_w0[base + 13], 32'h0000_2000);
                checkOutput("t2_word0", log_w1[base + 0], 32'h0000_FFFF);
                checkOutput("t2_word1", log_w1[base + 1], 32'h0000_5599);
                checkOutput("t2_word2", log_w1[base + 2], 32'h0000_AA66);
            end
            if (vecs[i].exp_error) begin
                @(negedge clk);
                checkOutput("timeout_issue_cycles", last_run, TIMEOUT + 1);
                checkOutput("timeout_cyc_low", {31'h0, wb0.cyc_o}, 32'h0);
            end
        end

        // Restart after the timeout: error clears and the stream begins again at FFFF.
        applyStimulus(24'h040000, 24'h000000, 4, 3, -1);
        waitEnd(20000);
        checkRun(24'h040000, 24'h000000, 1'b1, 1'b0, 14);

        // Back-to-back start on the first idle cycle after done, with new addresses.
        applyStimulus(24'h0A0000, 24'h010000, 2, 2, -1);
        waitEnd(20000);
        checkRun(24'h0A0000, 24'h010000, 1'b1, 1'b0, 14);

        // A second start while busy must not restart or relatch addresses.
        applyStimulus(24'h200000, 24'h000100, 3, 2, -1);
        waitWords(6, 5000);
        multi_addr  = 24'hFFFFFF;
        golden_addr = 24'h5A5A5A;
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("busy_during_restart", {31'h0, busy0}, 32'h1);
        waitEnd(20000);
        checkRun(24'h200000, 24'h000100, 1'b1, 1'b0, 14);

        // Reset in the middle of word 8 drops the bus and clears status at once.
        applyStimulus(24'h300000, 24'h000200, 3, 2, -1);
        waitWords(9, 5000);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("midreset_cyc", {31'h0, wb0.cyc_o}, 32'h0);
        checkOutput("midreset_stb", {31'h0, wb0.stb_o}, 32'h0);
        checkOutput("midreset_busy", {31'h0, busy0}, 32'h0);
        checkOutput("midreset_done", {31'h0, done0}, 32'h0);
        checkOutput("midreset_cyc_swap", {31'h0, wb1.cyc_o}, 32'h0);
        reset = 1'b0;

        // Randomised addresses and slave timing.
        for (int r = 0; r < 6; r++) begin
            logic [23:0] m;
            logic [23:0] g;
            int          d;
            int          h;
            m = 24'($urandom);
            g = 24'($urandom);
            d = int'($urandom_range(1, 6));
            h = int'($urandom_range(1, 12));
            applyStimulus(m, g, d, h, -1);
            waitEnd(20000);
            checkRun(m, g, 1'b1, 1'b0, 14);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
        $finish;
    end

endmodule

// File: doc/s6_icap_reboot_ctrl.md
Name: s6_icap_reboot_ctrl

Overview:
Wishbone master sequencer that drives the Spartan-6 ICAP Wishbone slave. It issues the UG380 IPROG command stream and so triggers a multiboot reconfiguration from a selected SPI flash address, with a golden fallback address. It sits between the firmware settings bus (start, addresses) and the ICAP slave port on the same clk.

Parameters:
SPI_RD_OPCODE, 8'h0B, SPI flash read opcode placed in GENERAL2 and GENERAL4 bits [15:8].
BITSWAP, 1, when 1 reverse the bit order within each byte of every word (ICAP_SPARTAN6 data ordering).
TIMEOUT, 1023, clk cycles allowed in any single ack wait before error; 10-bit counter.

Ports:
clk  in  1  system clock (54 MHz domain); all logic on posedge
reset  in  1  synchronous, active-high
start  in  1  one-cycle pulse; begins sequence when idle
multi_addr  in  24  multiboot image start address; latched on accepted start
golden_addr  in  24  fallback image address; latched on accepted start
busy  out  1  high from accepted start until DONE/ERR entered
done  out  1  sticky; sequence completed; cleared by next accepted start or reset
error  out  1  sticky; ack timeout; cleared by next accepted start or reset
cyc_o  out  1  Wishbone cycle
stb_o  out  1  Wishbone strobe
we_o  out  1  always 1 while cyc_o high, else 0
dat_o  out  32  [31:16]=0, [15:0]=current word (bit-swapped if BITSWAP)
ack_i  in  1  slave ack; may stay high for several clk cycles (slave runs on slower clk_icap)

Behaviour:
- Reset: state IDLE, all outputs 0, index=0, timeout counter=0, latched addresses=0.
- Word ROM, index 0..13: FFFF, AA99, 5566, 3261, multi[15:0], 3281, {OP,multi[23:16]}, 32A1, golden[15:0], 32C1, {OP,golden[23:16]}, 30A1, 000E, 2000. OP = SPI_RD_OPCODE.
- FSM states: IDLE, ACKLOW, ISSUE, NEXT, DONE, ERR.
- IDLE: on start, latch both addresses, clear done/error, index=0, busy=1, go to ACKLOW. All other inputs are ignored in IDLE.
- ACKLOW: wait for ack_i==0 so that a stale ack from the previous word is not reused. Counter increments each cycle. When ack_i==0, reset the counter and go to ISSUE. On counter==TIMEOUT, go to ERR.
- ISSUE: cyc_o=stb_o=we_o=1, dat_o=ROM[index], held stable. On the first cycle with ack_i==1, drop cyc/stb on the next edge and go to NEXT. On counter==TIMEOUT, drop cyc/stb and go to ERR.
- NEXT: if index==13, go to DONE; otherwise index+1 and go to ACKLOW.
- DONE: busy=0, done=1, return to IDLE in the same transition; done stays asserted.
- ERR: busy=0, error=1, cyc/stb=0, return to IDLE; error stays asserted.
- start while busy: ignored; no restart.
- Reset mid-sequence: immediate return to IDLE with cyc/stb low. The ICAP may hold a partial sync; the next sequence's leading FFFF/AA99 resynchronises it.
- Minimum 1 idle clk between strobes, plus any time ack_i stays high.
- Latency: 14 transactions. Each transaction costs at least 3 clk cycles plus the slave ack delay.

Decomposition:
- Package s6_icap_pkg: 16-bit constants ICAP_DUMMY, ICAP_SYNC0, ICAP_SYNC1, ICAP_WR_GEN1..GEN4, ICAP_WR_CMD, ICAP_CMD_IPROG, ICAP_NOOP; IPROG_LEN=14; state encoding.
- Sub-module s6_iprog_rom: combinational index[3:0] + addresses + opcode -> 16-bit word, with BITSWAP applied.

Test Plan:
1. Reset, then start with multi_addr=24'h040000, golden_addr=24'h000000, BITSWAP=0, slave model acks after 4 clk for 3 clk -> exactly 14 writes. Word 4=0000, word 6=0B04, word 12=000E, word 13=2000; done=1, busy=0.
2. BITSWAP=1, same run -> word1 dat_o[15:0]=5599, word2=AA66, word0=FFFF; dat_o[31:16]=0 on every write.
3. Slave holds ack_i high 10 clk per word -> each word is written once (no double-advance); total strobe count=14.
4. Slave never acks word 3 -> after TIMEOUT+1 clk cycles in ISSUE, cyc_o=0 and error=1. A new start clears error and restarts at word FFFF.
5. start pulsed again at word 5 -> ignored, sequence completes normally. Then assert reset during word 8 -> cyc_o=0 next edge, busy=0, done=0.
6. Back-to-back start immediately after done -> done clears, and the second sequence runs with the newly latched addresses.
